// File: rtl/cpu_controller_pkg.sv
`default_nettype none
// ============================================================================
// Package : cpu_pkg
// Opcode constants, phase enum and opcode helpers shared by the controller,
// the ALU and the testbench.
// Revision: 1.0
// ============================================================================
package cpu_pkg;

  parameter int OPW = 3;

  localparam logic [OPW-1:0] HLT = 3'd0;
  localparam logic [OPW-1:0] SKZ = 3'd1;
  localparam logic [OPW-1:0] ADD = 3'd2;
  localparam logic [OPW-1:0] AND = 3'd3;
  localparam logic [OPW-1:0] XOR = 3'd4;
  localparam logic [OPW-1:0] LDA = 3'd5;
  localparam logic [OPW-1:0] STO = 3'd6;
  localparam logic [OPW-1:0] JMP = 3'd7;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  // Opcodes that read an operand and land a result in the accumulator.
  function automatic logic is_aluop(input logic [OPW-1:0] op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_controller_decode.sv
`default_nettype none
// ============================================================================
// Module  : ctrl_decode
// Combinational Moore decode of (phase, opcode, zero, halted) to the strobes.
// Revision: 1.0
// ============================================================================
module ctrl_decode
  import cpu_pkg::*;
#(
  parameter int OPW = cpu_pkg::OPW
) (
  input  phase_t         phase,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           halted,
  output logic           sel,
  output logic           rd,
  output logic           ld_ir,
  output logic           inc_pc,
  output logic           ld_pc,
  output logic           ld_ac,
  output logic           wr,
  output logic           data_e,
  output logic           halt
);

  logic w_alu;
  logic w_sto;
  logic w_jmp;

  assign w_alu = is_aluop(opcode);
  assign w_sto = (opcode == STO);
  assign w_jmp = (opcode == JMP);

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    if (halted) begin
      halt = 1'b1;
    end else begin
      case (phase)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = (opcode == HLT);
        end
        OP_FETCH: begin
          rd = w_alu;
        end
        ALU_OP: begin
          rd     = w_alu;
          inc_pc = (opcode == SKZ) && zero;
          ld_pc  = w_jmp;
          data_e = w_sto;
        end
        STORE: begin
          rd     = w_alu;
          ld_ac  = w_alu;
          ld_pc  = w_jmp;
          wr     = w_sto;
          data_e = w_sto;
        end
        default: begin
          sel = 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/cpu_controller.sv
`default_nettype none
// ============================================================================
// Module  : cpu_controller
// 8-phase fetch/execute sequencer with sticky halt for the 8-bit RISC CPU.
// Optional macro CPU_CTRL_STEP_EN adds a 'step' input for single-stepping.
// Revision: 1.0
// ============================================================================
module cpu_controller #(
  parameter int NPHASE = 8,
  parameter int OPW    = cpu_pkg::OPW
) (
  input  logic           clk,
  input  logic           rst_n,
`ifdef CPU_CTRL_STEP_EN
  input  logic           step,
`endif
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  output logic           sel,
  output logic           rd,
  output logic           ld_ir,
  output logic           inc_pc,
  output logic           ld_pc,
  output logic           ld_ac,
  output logic           wr,
  output logic           data_e,
  output logic           halt
);

  import cpu_pkg::*;

  generate
    if (NPHASE != 8) begin : g_nphase_check
      $error("cpu_controller: NPHASE must be 8");
    end
  endgenerate

  phase_t phase_q;
  phase_t phase_d;
  logic   halted_q;
  logic   halted_d;
  logic   w_adv;
  logic   w_halt_now;

`ifdef CPU_CTRL_STEP_EN
  assign w_adv = step;
`else
  assign w_adv = 1'b1;
`endif

  assign w_halt_now = (phase_q == OP_ADDR) && (opcode == HLT);

  // Halting pins the phase at OP_ADDR; only reset releases it.
  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    if (w_adv && !halted_q) begin
      if (w_halt_now) begin
        halted_d = 1'b1;
      end else begin
        phase_d = phase_t'(phase_q + 3'd1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  ctrl_decode #(
    .OPW(OPW)
  ) u_decode (
    .phase  (phase_q),
    .opcode (opcode),
    .zero   (zero),
    .halted (halted_q),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .data_e (data_e),
    .halt   (halt)
  );

endmodule
`default_nettype wire

// File: tb/tb_cpu_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_cpu_controller
// Self-checking bench for cpu_controller against a phase/rule reference model.
// Revision: 1.0
// ============================================================================
module tb_cpu_controller;
  import cpu_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       step;
  logic [2:0] opcode;
  logic       zero;
  logic sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;

  int n_checks;
  int n_fails;
  int m_phase;
  bit m_halted;

  cpu_controller dut (
    .clk    (clk),
    .rst_n  (rst_n),
`ifdef CPU_CTRL_STEP_EN
    .step   (step),
`endif
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .data_e (data_e),
    .halt   (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %b expected %b (phase %0d halted %0d op %0d z %0b)",
               tag, got, exp, m_phase, m_halted, opcode, zero);
    end
  endtask

  // Bit order {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt}, from the rule table.
  function automatic logic [8:0] expect_outs(int ph, logic [2:0] op, logic z, bit h);
    bit alu, is_sto, is_jmp;
    if (h) return 9'b000000001;
    alu    = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
    is_sto = (op == 3'd6);
    is_jmp = (op == 3'd7);
    return { ph <= 3,
             (ph >= 1 && ph <= 3) || (ph >= 5 && alu),
             ph == 2 || ph == 3,
             ph == 4 || (ph == 6 && op == 3'd1 && z),
             (ph == 6 || ph == 7) && is_jmp,
             ph == 7 && alu,
             ph == 7 && is_sto,
             ph >= 6 && is_sto,
             ph == 4 && op == 3'd0 };
  endfunction

  function automatic logic [8:0] dut_outs();
    return {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};
  endfunction

  task automatic compare(input string tag);
    check(tag, dut_outs(), expect_outs(m_phase, opcode, zero, m_halted));
    check("wr_ldir_excl", {8'd0, wr & ld_ir}, 9'd0);
    check("rd_wr_excl",   {8'd0, rd & wr},    9'd0);
  endtask

  // One clock: advance the model by the sequencing rules, then sample 1ns later.
  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_n && step && !m_halted) begin
      if (m_phase == 4 && opcode == 3'd0) m_halted = 1'b1;
      else m_phase = (m_phase + 1) % 8;
    end
    #1;
    compare(tag);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    m_phase = 0;
    m_halted = 1'b0;
    #1;
    check("reset_outs", dut_outs(), 9'b100000000);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_instr(input logic [2:0] op, input logic z, input string tag);
    opcode = op;
    zero   = z;
    repeat (8) tick(tag);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    step   = 1'b1;
    opcode = 3'd2;
    zero   = 1'b0;
    rst_n  = 1'b1;
    #2;
    apply_reset();

    run_instr(3'd2, 1'b0, "add");
    run_instr(3'd6, 1'b0, "sto");
    run_instr(3'd1, 1'b1, "skz_z1");
    run_instr(3'd1, 1'b0, "skz_z0");
    run_instr(3'd7, 1'b0, "jmp");
    run_instr(3'd5, 1'b1, "lda");

    // Reset asserted between edges in the middle of an instruction.
    opcode = 3'd2;
    repeat (5) tick("pre_mid_reset");
    #2;
    apply_reset();
    tick("post_mid_reset");
    check("post_reset_phase1", dut_outs(), 9'b110000000);
    repeat (7) tick("post_mid_reset");

`ifdef CPU_CTRL_STEP_EN
    opcode = 3'd3;
    repeat (2) tick("pre_step");
    step = 1'b0;
    repeat (5) tick("step_hold");
    step = 1'b1;
    tick("step_pulse");
    step = 1'b0;
    tick("step_hold2");
    step = 1'b1;
    repeat (3) tick("step_resume");
`endif

    // Halt: sticky for 20+ cycles, cleared only by reset.
    opcode = 3'd0;
    zero   = 1'b1;
    repeat (4) tick("hlt_run");
    repeat (24) tick("hlt_stuck");
    check("hlt_sticky", {8'd0, halt}, 9'd1);
    opcode = 3'd2;
    tick("hlt_op_change");
    #2;
    apply_reset();

    for (int i = 0; i < 80; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      if (op == 3'd0 && ($urandom_range(0, 3) != 0)) op = 3'($urandom_range(1, 7));
      run_instr(op, 1'($urandom_range(0, 1)), "rand");
      if (m_halted) begin
        repeat (3) tick("rand_halt");
        #2;
        apply_reset();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
